// File: rtl/mem_arbiter.sv
// Round-robin read arbiter that shares one single-port word memory between NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_data
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    ptr_q;
  logic                pick_vld;
  logic [OWN_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   pick_addr;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                wait_expired;

  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  // Search upward from the last owner; the owner register doubles as the RR pointer.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_addr = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = OWN_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == OWN_W'(i)) pick_addr = addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) state_d = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wait_expired) state_d = RESP;
`endif
      end
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= OWN_W'(NUM_REQ - 1);
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      gnt       <= '0;
      mem_req   <= 1'b0;
      rsp_valid <= '0;
      if (state_q == IDLE && pick_vld) begin
        ptr_q    <= pick_idx;
        mem_addr <= pick_addr;
        gnt      <= ONE_HOT0 << pick_idx;
        mem_req  <= 1'b1;
      end
      if (state_q == WAIT && state_d == RESP) begin
        rsp_valid <= ONE_HOT0 << ptr_q;
        rsp_data  <= mem_ready ? mem_data : '0;
`ifdef MEM_ARB_TIMEOUT_EN
        rsp_err   <= !mem_ready;
`endif
      end
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, round-robin rotation, address hold,
// early req drop, reset during WAIT and (with MEM_ARB_TIMEOUT_EN) the timeout response.
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      busy;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_data;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gnt and rsp_valid must each be at most one-hot and never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert ($onehot0(gnt) && $onehot0(rsp_valid) && !((|gnt) && (|rsp_valid))) else begin
        bad++;
        $error("FAIL excl observed=gnt %b rsp %b expected=exclusive one-hot", gnt, rsp_valid);
      end
    end
  end

  // Current cycle is IDLE with req already driven; memory answers lat cycles after mem_req.
  task automatic do_txn(input logic [1:0] g, input logic [11:0] a, input logic [15:0] d,
                        input int lat);
    tick;
    chk("gnt", {30'd0, gnt}, {30'd0, g});
    chk("mem_req", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", {20'd0, mem_addr}, {20'd0, a});
    chk("busy_hi", {31'd0, busy}, 32'd1);
    tick;
    chk("mem_req_pulse", {31'd0, mem_req}, 32'd0);
    chk("gnt_pulse", {30'd0, gnt}, 32'd0);
    for (int i = 1; i < lat; i++) tick;
    mem_ready = 1'b1;
    mem_data  = d;
    chk("mem_addr_hold", {20'd0, mem_addr}, {20'd0, a});
    chk("rsp_early", {30'd0, rsp_valid}, 32'd0);
    tick;
    mem_ready = 1'b0;
    mem_data  = 16'hdead;
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, g});
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, d});
    chk("rsp_err", {31'd0, rsp_err}, 32'd0);
    tick;
    chk("rsp_pulse", {30'd0, rsp_valid}, 32'd0);
    chk("busy_lo", {31'd0, busy}, 32'd0);
    chk("rsp_hold", {16'd0, rsp_data}, {16'd0, d});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; addr = '0; mem_ready = 1'b0; mem_data = 16'hbeef;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick;

    // single read from requester 0
    req = 2'b01; addr[11:0] = 12'h004;
    chk("t1_idle_gnt", {30'd0, gnt}, 32'd0);
    do_txn(2'b01, 12'h004, 16'h1007, 2);
    req = 2'b00;
    tick;
    chk("t1_no_regrant", {30'd0, gnt}, 32'd0);

    // both requesting from reset: grants alternate starting with 0
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    addr = {12'h020, 12'h010};
    req  = 2'b11;
    do_txn(2'b01, 12'h010, 16'ha010, 2);
    do_txn(2'b10, 12'h020, 16'ha020, 3);
    do_txn(2'b01, 12'h010, 16'hb010, 1);
    do_txn(2'b10, 12'h020, 16'hb020, 2);
    req = 2'b00;

    // addr1 changes during WAIT; latched address must persist
    tick;
    req = 2'b10; addr[23:12] = 12'h020;
    tick;
    chk("t3_gnt", {30'd0, gnt}, 32'd2);
    chk("t3_mem_addr", {20'd0, mem_addr}, 32'h020);
    tick;
    addr[23:12] = 12'h030;
    tick;
    chk("t3_addr_hold", {20'd0, mem_addr}, 32'h020);
    mem_ready = 1'b1; mem_data = 16'h2020;
    tick;
    mem_ready = 1'b0;
    chk("t3_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t3_rsp_data", {16'd0, rsp_data}, 32'h2020);
    tick;
    req = 2'b00;

    // requester 0 drops req right after its grant
    tick;
    req = 2'b01; addr[11:0] = 12'h044;
    tick;
    chk("t6_gnt", {30'd0, gnt}, 32'd1);
    tick;
    req = 2'b00;
    tick;
    mem_ready = 1'b1; mem_data = 16'h5044;
    tick;
    mem_ready = 1'b0;
    chk("t6_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t6_rsp_data", {16'd0, rsp_data}, 32'h5044);
    tick;
    chk("t6_busy", {31'd0, busy}, 32'd0);

    // reset during WAIT, then a stale mem_ready two cycles after release
    req = 2'b10; addr[23:12] = 12'h060;
    tick;
    chk("t4_gnt", {30'd0, gnt}, 32'd2);
    tick;
    chk("t4_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t4_async");
    tick;
    rst_n = 1'b1; req = 2'b00;
    tick;
    tick;
    mem_ready = 1'b1; mem_data = 16'hbad0;
    tick;
    mem_ready = 1'b0;
    chk_idle_outputs("t4_stale");
    tick;
    chk("t4_no_rsp", {30'd0, rsp_valid}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: error response after 8 WAIT cycles
    req = 2'b01; addr[11:0] = 12'h070; mem_data = 16'h7777;
    tick;
    chk("to_gnt", {30'd0, gnt}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("to_wait", {30'd0, rsp_valid}, 32'd0);
    end
    tick;
    chk("to_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_data", {16'd0, rsp_data}, 32'd0);
    tick;
    req = 2'b10; addr[23:12] = 12'h080;
    chk("to_busy", {31'd0, busy}, 32'd0);
    do_txn(2'b10, 12'h080, 16'h6080, 3);
    req = 2'b00;
`endif

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
